// File: rtl/subneg_core.sv
// subneg_core: multi-cycle SUBNEG/SUBLEQ processor core.
// One word access per state over a req/ack handshake; six states per instruction.
module subneg_core #(
  parameter int WIDTH      = 8,
  parameter int ADDR_W     = 8,
  parameter int RESET_PC   = 0,
  parameter int BRANCH_LEQ = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step_en,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FA,
    S_FB,
    S_FC,
    S_RA,
    S_RB,
    S_WR,
    S_HALT
  } state_e;

  localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [ADDR_W-1:0] b_q, b_d;
  logic [ADDR_W-1:0] c_q, c_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  ret_q, ret_d;

  logic              neg, zero, take, acc;
  logic [ADDR_W-1:0] npc;

  // wdata_q holds opB - opA while in WRITE, so the branch test reads it directly
  assign neg  = wdata_q[WIDTH-1];
  assign zero = (wdata_q == '0);
  assign take = neg | ((BRANCH_LEQ != 0) & zero);
  assign npc  = take ? c_q : pc_q + ADDR_W'(3);
  assign acc  = req_q & mem_ack;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    addr_d  = addr_q;
    opa_d   = opa_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    we_d    = we_q;
    ret_d   = ret_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FA;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = pc_q;
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_FA;
          pc_d    = PC0;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = PC0;
        end
      end
      S_FA: begin
        if (acc) begin
          a_d     = mem_rdata[ADDR_W-1:0];
          state_d = S_FB;
          addr_d  = pc_q + ADDR_W'(1);
        end
      end
      S_FB: begin
        if (acc) begin
          b_d     = mem_rdata[ADDR_W-1:0];
          state_d = S_FC;
          addr_d  = pc_q + ADDR_W'(2);
        end
      end
      S_FC: begin
        if (acc) begin
          c_d     = mem_rdata[ADDR_W-1:0];
          state_d = S_RA;
          addr_d  = a_q;
        end
      end
      S_RA: begin
        if (acc) begin
          opa_d   = mem_rdata;
          state_d = S_RB;
          addr_d  = b_q;
        end
      end
      S_RB: begin
        if (acc) begin
          wdata_d = mem_rdata - opa_q;
          state_d = S_WR;
          we_d    = 1'b1;
          addr_d  = b_q;
        end
      end
      S_WR: begin
        if (acc) begin
          ret_d = ret_q + CNT_W'(1);
          req_d = 1'b0;
          if (npc == pc_q) begin
            state_d = S_HALT;
          end else if (step_en) begin
            state_d = S_IDLE;
            pc_d    = npc;
          end else begin
            state_d = S_FA;
            pc_d    = npc;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = npc;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= PC0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      addr_q  <= '0;
      opa_q   <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      addr_q  <= addr_d;
      opa_q   <= opa_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      ret_q   <= ret_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign pc_out    = pc_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted    = (state_q == S_HALT);
  assign retired   = ret_q;

endmodule
